regfile_wr_arbiter: RTL

//   Shares the register file's single write port between two writeback requesters:
//   A (ALU result) and B (load/memory result).

---
 rtl/regfile_wr_arbiter_pkg.sv | 35 +++
 rtl/regfile_wr_arbiter_scoreboard.sv | 73 +++++++
 rtl/regfile_wr_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/regfile_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// regfile_wr_arbiter_pkg
//   Shared definitions for the register-file write arbiter:
//     - default register-index and data widths, register count
//     - requester id encoding (REQ_A = ALU, REQ_B = load/memory)
//     - round-robin pick helper used by the top level
// ---------------------------------------------------------------------------
package regfile_wr_arbiter_pkg;

  localparam int DEF_REG_NUM_BITWIDTH = 5;
  localparam int DEF_WORD_BITWIDTH    = 32;
  localparam int DEF_REG_COUNT        = 2 ** DEF_REG_NUM_BITWIDTH;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  // Winner for this cycle. With both valid, the requester that did not win
  // last time goes. With none valid the result is irrelevant, because the
  // caller gates ready with valid.
  function automatic req_id_e rr_pick(input logic a_valid,
                                      input logic b_valid,
                                      input req_id_e last_grant);
    req_id_e w_pick;
    if (a_valid && b_valid)
      w_pick = (last_grant == REQ_A) ? REQ_B : REQ_A;
    else if (b_valid)
      w_pick = REQ_B;
    else
      w_pick = REQ_A;
    return w_pick;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_wr_arbiter_scoreboard
//   Pending-write scoreboard for the register file.
//   Ports:
//     clk, rst                 clock, synchronous active-low reset
//     i_set_valid/i_set_reg    issue marks a register as pending
//     o_set_ready              target not already pending (reg 0 always ready)
//     i_clr_en/i_clr_reg       regfile commit of the registered write
//     i_rs1/i_rs2              decode source registers
//     o_hazard1/o_hazard2      source has a pending write (combinational)
//     o_err_spurious           sticky: commit to a register that was not pending
// ---------------------------------------------------------------------------
module regfile_wr_arbiter_scoreboard
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int REG_NUM_BITWIDTH = DEF_REG_NUM_BITWIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_set_valid,
  input  logic [REG_NUM_BITWIDTH-1:0] i_set_reg,
  output logic                        o_set_ready,
  input  logic                        i_clr_en,
  input  logic [REG_NUM_BITWIDTH-1:0] i_clr_reg,
  input  logic [REG_NUM_BITWIDTH-1:0] i_rs1,
  input  logic [REG_NUM_BITWIDTH-1:0] i_rs2,
  output logic                        o_hazard1,
  output logic                        o_hazard2,
  output logic                        o_err_spurious
);

  localparam int REG_COUNT = 2 ** REG_NUM_BITWIDTH;

  logic [REG_COUNT-1:0] r_pending;
  logic [REG_COUNT-1:0] w_pending_nxt;
  logic                 r_err;
  logic                 w_set_fire;
  logic                 w_spurious;

  // x0 never becomes pending, so a mark on it is always allowed and dropped.
  assign o_set_ready = rst && ((i_set_reg == '0) || !r_pending[i_set_reg]);
  assign w_set_fire  = i_set_valid && o_set_ready && (i_set_reg != '0);

  // The write port never carries x0 with enable high, so no x0 guard here.
  assign w_spurious  = i_clr_en && !r_pending[i_clr_reg];

  // Clear first, then set: a set and a clear of the same register on the
  // same edge leaves the bit pending.
  always_comb begin
    w_pending_nxt = r_pending;
    if (i_clr_en)
      w_pending_nxt[i_clr_reg] = 1'b0;
    if (w_set_fire)
      w_pending_nxt[i_set_reg] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pending <= '0;
      r_err     <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_spurious)
        r_err <= 1'b1;
    end
  end

  // No bypass from the write port: the hazard drops the cycle after commit.
  assign o_hazard1      = (i_rs1 != '0) && r_pending[i_rs1];
  assign o_hazard2      = (i_rs2 != '0) && r_pending[i_rs2];
  assign o_err_spurious = r_err;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wr_arbiter
//   Shares the single register-file write port between requester A (ALU)
//   and requester B (load/memory) with round-robin arbitration and
//   valid/ready handshakes; the winning write is registered onto the port.
//   A pending-write scoreboard lets decode stall on RAW/WAW hazards.
//   Ports:
//     clk, rst                          clock, synchronous active-low reset
//     req_a_* / req_b_*                 valid, reg, data in; ready out (comb)
//     sb_set_valid/sb_set_reg/_ready    scoreboard mark from issue
//     rs1, rs2 / hazard1, hazard2       decode hazard lookups (comb)
//     regToWrite, write_data, doRegWrite  registered regfile write port
//     err_spurious                      sticky commit-to-non-pending flag
// ---------------------------------------------------------------------------
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int REG_NUM_BITWIDTH = DEF_REG_NUM_BITWIDTH,
  parameter int WORD_BITWIDTH    = DEF_WORD_BITWIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_a_valid,
  input  logic [REG_NUM_BITWIDTH-1:0] req_a_reg,
  input  logic [WORD_BITWIDTH-1:0]    req_a_data,
  output logic                        req_a_ready,
  input  logic                        req_b_valid,
  input  logic [REG_NUM_BITWIDTH-1:0] req_b_reg,
  input  logic [WORD_BITWIDTH-1:0]    req_b_data,
  output logic                        req_b_ready,
  input  logic                        sb_set_valid,
  input  logic [REG_NUM_BITWIDTH-1:0] sb_set_reg,
  output logic                        sb_set_ready,
  input  logic [REG_NUM_BITWIDTH-1:0] rs1,
  input  logic [REG_NUM_BITWIDTH-1:0] rs2,
  output logic                        hazard1,
  output logic                        hazard2,
  output logic [REG_NUM_BITWIDTH-1:0] regToWrite,
  output logic [WORD_BITWIDTH-1:0]    write_data,
  output logic                        doRegWrite,
  output logic                        err_spurious
);

  req_id_e                     r_last_grant;
  req_id_e                     w_pick;
  logic                        w_fire;
  logic [REG_NUM_BITWIDTH-1:0] w_sel_reg;
  logic [WORD_BITWIDTH-1:0]    w_sel_data;
  logic                        w_sel_real;

  logic                        r_we;
  logic [REG_NUM_BITWIDTH-1:0] r_reg;
  logic [WORD_BITWIDTH-1:0]    r_data;

  // Ready looks only at the valids and the grant history, never at the
  // requesters' reg/data, so there is no combinational path from data.
  always_comb begin
    w_pick      = rr_pick(req_a_valid, req_b_valid, r_last_grant);
    req_a_ready = rst && req_a_valid && (w_pick == REQ_A);
    req_b_ready = rst && req_b_valid && (w_pick == REQ_B);
  end

  assign w_fire     = req_a_ready || req_b_ready;
  assign w_sel_reg  = req_b_ready ? req_b_reg  : req_a_reg;
  assign w_sel_data = req_b_ready ? req_b_data : req_a_data;
  // x0 transfers are accepted but never reach the port.
  assign w_sel_real = w_fire && (w_sel_reg != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last_grant <= REQ_B;
      r_we         <= 1'b0;
      r_reg        <= '0;
      r_data       <= '0;
    end else begin
      r_we <= w_sel_real;
      if (w_fire)
        r_last_grant <= w_pick;
      // Index/data hold when nothing real is written.
      if (w_sel_real) begin
        r_reg  <= w_sel_reg;
        r_data <= w_sel_data;
      end
    end
  end

  assign doRegWrite = r_we;
  assign regToWrite = r_reg;
  assign write_data = r_data;

  // Commit clears on the same edge the regfile stores the data.
  regfile_wr_arbiter_scoreboard #(
    .REG_NUM_BITWIDTH(REG_NUM_BITWIDTH)
  ) u_sb (
    .clk            (clk),
    .rst            (rst),
    .i_set_valid    (sb_set_valid),
    .i_set_reg      (sb_set_reg),
    .o_set_ready    (sb_set_ready),
    .i_clr_en       (r_we),
    .i_clr_reg      (r_reg),
    .i_rs1          (rs1),
    .i_rs2          (rs2),
    .o_hazard1      (hazard1),
    .o_hazard2      (hazard2),
    .o_err_spurious (err_spurious)
  );

endmodule
